// File: rtl/swivm_uart_tx.sv
// swivm_uart_tx: buffered 8N1 serial transmitter for the swivm CPU character
// output. One-cycle write strobes are queued in a small FIFO (no backpressure
// towards the CPU; dropped bytes set a sticky overflow flag) and each byte is
// sent LSB first as start bit, 8 data bits, stop bit.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   outbyte       character from the CPU
//   outbyte_valid one-cycle write strobe for outbyte
//   txd           serial line, idles high, driven from a register
//   busy          FSM not idle or FIFO non-empty
//   fifo_count    bytes currently held in the FIFO (0..2**FIFO_AW)
//   overflow      sticky, set when a byte is dropped; cleared by reset only
module swivm_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         outbyte,
  input  logic               outbyte_valid,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [7:0]         sh, sh_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2:0]         bitidx, bitidx_n;
  logic               txd_n;
  logic               pop, push, cnt_done;

  // A pop in the same edge frees a slot, so a full FIFO still accepts a write.
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign push     = outbyte_valid && ((fifo_count != FULL) || pop);
  assign cnt_done = (cnt == CNT_LAST);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (outbyte_valid && !push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: only slots behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= outbyte;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      bitidx <= '0;
      txd    <= 1'b1;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      cnt    <= cnt_n;
      bitidx <= bitidx_n;
      txd    <= txd_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n  = state;
    sh_n     = sh;
    cnt_n    = cnt;
    bitidx_n = bitidx;
    case (state)
      IDLE: begin
        if (pop) begin
          state_n = START;
          sh_n    = mem[rptr];
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt_done) begin
          state_n  = DATA;
          cnt_n    = '0;
          bitidx_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          if (bitidx == 3'd7) state_n  = STOP;
          else                bitidx_n = bitidx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: computed from the next state so the registered txd lines
  // up with the state it belongs to.
  always_comb begin
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Self-checking bench for swivm_uart_tx (CLKS_PER_BIT=4, FIFO depth 16).
// A frame-level model (byte queue + position within the current frame) gives
// the expected outputs every cycle; a small serial decoder recovers bytes
// from txd; directed literal checks pin the model on the key scenarios.
module tb_swivm_uart_tx;

  localparam int C     = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic [7:0]    outbyte;
  logic          outbyte_valid;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  swivm_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .outbyte(outbyte), .outbyte_valid(outbyte_valid),
    .txd(txd), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // ---------------- model ----------------
  logic [7:0] mq[$];
  bit         m_active;
  int         m_k;
  logic [7:0] m_cur;
  bit         m_ovf;

  task automatic model_clear();
    mq.delete();
    m_active = 0;
    m_k      = 0;
    m_cur    = '0;
    m_ovf    = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b);
    bit pop, acc;
    pop = !m_active && (mq.size() != 0);
    acc = v && ((mq.size() < DEPTH) || pop);
    if (v && !acc) m_ovf = 1;
    if (m_active) begin
      m_k++;
      if (m_k == 10*C) m_active = 0;
    end
    if (pop) begin
      m_cur    = mq.pop_front();
      m_k      = 0;
      m_active = 1;
    end
    if (acc) mq.push_back(b);
  endtask

  function automatic logic exp_txd();
    int bi;
    if (!m_active) return 1'b1;
    bi = m_k / C;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return m_cur[bi-1];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_all();
    check("txd", int'(txd), int'(exp_txd()));
    check("busy", int'(busy), int'(m_active || (mq.size() != 0)));
    check("fifo_count", int'(fifo_count), mq.size());
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  // ---------------- serial decoder ----------------
  bit         rx_busy;
  int         rx_ph;
  logic [7:0] rx_byte;
  logic       prev_txd;
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];

  task automatic rx_clear();
    rx_busy  = 0;
    rx_ph    = 0;
    rx_byte  = '0;
    prev_txd = 1'b1;
    rx_bytes.delete();
    rx_starts.delete();
  endtask

  task automatic rx_step();
    if (!rx_busy) begin
      if (prev_txd && !txd) begin
        rx_busy = 1;
        rx_ph   = 0;
        rx_starts.push_back(edge_n);
      end
    end else begin
      rx_ph++;
      for (int j = 1; j <= 8; j++)
        if (rx_ph == C/2 + C*j) rx_byte[j-1] = txd;
      if (rx_ph == C/2 + 9*C) begin
        check("rx_stop_bit", int'(txd), 1);
        rx_bytes.push_back(rx_byte);
        rx_busy = 0;
      end
    end
    prev_txd = txd;
  endtask

  // One clock: drive inputs, model follows the edge, compare on the falling edge.
  task automatic tick(input logic v, input logic [7:0] b);
    outbyte_valid = v;
    outbyte       = b;
    @(posedge clk);
    model_edge(v, b);
    @(negedge clk);
    edge_n++;
    check_all();
    rx_step();
    outbyte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    rx_clear();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    reset  = 1'b0;
    edge_n = 0;
  endtask

  logic [9:0] frame41;

  initial begin
    reset         = 1'b1;
    outbyte       = '0;
    outbyte_valid = 1'b0;
    model_clear();
    rx_clear();

    // Reset values, then a long quiet period.
    do_reset();
    check("reset_txd", int'(txd), 1);
    check("reset_count", int'(fifo_count), 0);
    idle(1000);
    check("idle_txd", int'(txd), 1);
    check("idle_busy", int'(busy), 0);

    // Single byte 0x41: line pattern start,1,0,0,0,0,0,1,0,stop.
    do_reset();
    frame41 = 10'b1_0100_0001_0;
    tick(1'b1, 8'h41);
    check("single_count_e1", int'(fifo_count), 1);
    tick(1'b0, 8'h00);
    check("single_count_e2", int'(fifo_count), 0);
    check("single_start", int'(txd), 0);
    for (int j = 1; j < 40; j++) begin
      tick(1'b0, 8'h00);
      check("single_bit", int'(txd), int'(frame41[j/C]));
    end
    check("single_busy_e41", int'(busy), 1);
    tick(1'b0, 8'h00);
    check("single_busy_e42", int'(busy), 0);
    idle(4);
    check("single_rx_n", rx_bytes.size(), 1);
    if (rx_bytes.size() == 1) check("single_rx_byte", int'(rx_bytes[0]), 'h41);

    // Back-to-back 0x55, 0xAA.
    do_reset();
    tick(1'b1, 8'h55);
    check("b2b_count_e1", int'(fifo_count), 1);
    tick(1'b1, 8'hAA);
    check("b2b_count_e2", int'(fifo_count), 1);
    idle(40);
    check("b2b_count_e42", int'(fifo_count), 1);
    tick(1'b0, 8'h00);
    check("b2b_count_e43", int'(fifo_count), 0);
    idle(45);
    check("b2b_rx_n", rx_bytes.size(), 2);
    check("b2b_starts_n", rx_starts.size(), 2);
    if (rx_bytes.size() == 2) begin
      check("b2b_rx0", int'(rx_bytes[0]), 'h55);
      check("b2b_rx1", int'(rx_bytes[1]), 'hAA);
    end
    if (rx_starts.size() == 2) check("b2b_spacing", rx_starts[1] - rx_starts[0], 41);

    // Overflow: 0x00..0x11 on edges 1..18; 0x11 is dropped.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(1'b1, 8'(i));
      if (i == 16) begin
        check("ovf_count_e17", int'(fifo_count), 16);
        check("ovf_flag_e17", int'(overflow), 0);
      end
    end
    check("ovf_flag_e18", int'(overflow), 1);
    idle(17*41 + 20);
    check("ovf_rx_n", rx_bytes.size(), 17);
    for (int i = 0; i < rx_bytes.size() && i < 17; i++)
      check("ovf_rx_byte", int'(rx_bytes[i]), i);
    check("ovf_sticky", int'(overflow), 1);

    // Full FIFO plus pop on the same edge.
    do_reset();
    tick(1'b1, 8'h3C);
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'hC0 + i));
    check("full_count_e17", int'(fifo_count), 16);
    idle(25);
    check("full_txd_stop", int'(txd), 1);
    tick(1'b1, 8'hE7);
    check("full_pop_count", int'(fifo_count), 16);
    check("full_pop_ovf", int'(overflow), 0);
    idle(50);

    // Reset during data bit 3 of 0x00, with another byte queued.
    do_reset();
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h99);
    idle(16);
    check("rst_pre_txd", int'(txd), 0);
    #1 reset = 1'b1;
    #1;
    check("rst_async_txd", int'(txd), 1);
    check("rst_async_count", int'(fifo_count), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_ovf", int'(overflow), 0);
    do_reset();
    idle(200);
    check("rst_after_frames", rx_starts.size(), 0);

    // Randomized traffic with varying write density.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned pct;
      pct = $urandom_range(2, 60);
      for (int i = 0; i < 500; i++)
        tick($urandom_range(0, 99) < pct, 8'($urandom));
    end
    idle(17*41 + 10);
    check("rand_drained", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
